imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the decode stage. It accepts one instruction word plus its PC per valid/ready transfer, then produces three results: the sign-extended immediate at XLEN bits, the format used, and the branch/jump/AUIPC target (pc + imm). Results are registered behind a 2-entry skid buffer, so fetch and execute can stall independently without combinational ready paths.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of all held and incoming entries
- in_valid  in  1  upstream has a transfer
- in_ready  out  1  block can accept; registered, equals "skid entry empty"
- instr  in  32  raw instruction word
- pc  in  XLEN  PC of instr
- ImmSrc  in  instr_format  format select; ignored when IMM_AUTO_DECODE_EN is defined
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- ImmOp  out  XLEN  sign-extended immediate
- PcTarget  out  XLEN  pc + ImmOp, modulo 2^XLEN
- Format  out  instr_format  format actually applied

## Operation
- Extraction. Every format sign-extends from instr[31] to XLEN.
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - UI: {instr[31:12], 12'b0}; bits above 31 are copies of instr[31] when XLEN=64
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - Any other ImmSrc encoding is treated as I, and Format reports I.
- PcTarget is computed for every entry. Carry out is discarded.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: output register valid, skid empty.
  - FULL: both entries valid.
- Transitions:
  - EMPTY: accept → ONE.
  - ONE: accept and no pop → FULL. Pop and no accept → EMPTY. Otherwise stay.
  - FULL: pop → ONE; the skid entry moves to the output register. No accept is possible in FULL.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- Order is strictly FIFO.
- ImmOp, PcTarget and Format must not change while out_valid=1 and out_ready=0.
- Flush has priority over all events. The state goes to EMPTY on the next edge, and a transfer presented in the same cycle is dropped.

## Timing
- Latency 1 cycle: an accept at edge N gives out_valid=1 after edge N.
- Throughput is 1 per cycle while out_ready=1.
- in_ready falls the cycle after the buffer becomes FULL and rises the cycle after a pop from FULL.
- in_ready never depends combinationally on out_ready.
- Reset values:
  - out_valid=0, in_ready=1, state EMPTY
  - ImmOp=0, PcTarget=0, Format=I
- Reset mid-operation discards all entries immediately (asynchronous).
- Simultaneous accept and pop in ONE keeps ONE, with the new data in the output register.

## Configuration
- IMM_AUTO_DECODE_EN defined: Format is derived from instr[6:0] and the ImmSrc port is ignored.
  - I: 0010011, 0000011, 1100111, 1110011
  - S: 0100011
  - UI: 0110111, 0010111
  - B: 1100011
  - J: 1101111
  - Any other opcode: I
- IMM_AUTO_DECODE_EN undefined: the ImmSrc port selects the format directly.

## Structure
- types_pkg carries:
  - instr_format, unchanged encodings I, S, UI, B, J
  - opcode localparams for auto decode
  - a struct imm_entry_t {ImmOp, PcTarget, Format} parameterised via XLEN-sized fields
- Sub-module imm_extract: purely combinational.
  - Inputs: instr, format. Output: XLEN immediate.
  - Instantiated once, ahead of the skid buffer. The adder sits alongside it.

## Test plan
- XLEN=32, I, instr 0xFFF00093, pc 0x0 → ImmOp 0xFFFFFFFF, PcTarget 0xFFFFFFFF, out_valid one cycle after accept.
- XLEN=32, B, instr 0xFE000EE3, pc 0x100 → ImmOp 0xFFFFFFFC, PcTarget 0x000000FC.
- XLEN=64, UI, instr 0x800000B7 → ImmOp 0xFFFFFFFF80000000. J, instr 0x0080006F, pc 0x20 → ImmOp 0x8, PcTarget 0x28.
- Back-to-back stream A, B, C with out_ready=0 from the second cycle:
  - A and B are held; in_ready=0 after B.
  - C waits.
  - Releasing out_ready yields A, B, C in order with no loss or duplication.
- FULL buffer, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flushed transfer never appears.
- rst_n low while FULL → out_valid=0 and in_ready=1 immediately. Under IMM_AUTO_DECODE_EN, opcode 0100011 with ImmSrc=J gives Format=S.

Source files
------------

// File: rtl/types_pkg.sv
// Shared types for the immediate generator: instruction formats, opcodes,
// skid-buffer states and format helper functions.
package types_pkg;

  typedef enum logic [2:0] {
    I  = 3'd0,
    S  = 3'd1,
    UI = 3'd2,
    B  = 3'd3,
    J  = 3'd4
  } instr_format;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Unused encodings of the format select collapse onto I.
  function automatic instr_format legalize_format(input instr_format f);
    instr_format r;
    case (f)
      I, S, UI, B, J: r = f;
      default:        r = I;
    endcase
    return r;
  endfunction

  function automatic instr_format decode_opcode(input logic [6:0] opc);
    instr_format r;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: r = I;
      OPC_STORE:                                  r = S;
      OPC_LUI, OPC_AUIPC:                         r = UI;
      OPC_BRANCH:                                 r = B;
      OPC_JAL:                                    r = J;
      default:                                    r = I;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction: gathers the scattered immediate bits of
// one instruction word and sign-extends them from instr[31] to XLEN.
module imm_extract
  import types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  instr_format     format,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32_s;
  logic        unused_opcode_s;

  assign unused_opcode_s = ^instr[6:0];

  // Build the 32-bit immediate for the selected format.
  always_comb begin
    imm32_s = {{20{instr[31]}}, instr[31:20]};
    case (format)
      I:       imm32_s = {{20{instr[31]}}, instr[31:20]};
      S:       imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      UI:      imm32_s = {instr[31:12], 12'h000};
      B:       imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                          instr[11:8], 1'b0};
      J:       imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                          instr[30:21], 1'b0};
      default: imm32_s = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  // The 32-bit value is already sign-correct, so widening replicates bit 31.
  assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer on its output.
// Define IMM_AUTO_DECODE_EN to derive the format from the opcode instead of ImmSrc.
module imm_gen_pipe
  import types_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  instr_format     ImmSrc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ImmOp,
  output logic [XLEN-1:0] PcTarget,
  output instr_format     Format
);

  typedef struct packed {
    logic [XLEN-1:0] imm_op;
    logic [XLEN-1:0] pc_target;
    instr_format     fmt;
  } imm_entry_t;

  localparam imm_entry_t ENTRY_RST = '{imm_op: '0, pc_target: '0, fmt: I};

  instr_format     fmt_s;
  logic [XLEN-1:0] imm_s;
  imm_entry_t      new_entry_s;

`ifdef IMM_AUTO_DECODE_EN
  logic unused_immsrc_s;
  assign unused_immsrc_s = ^ImmSrc;
  assign fmt_s = decode_opcode(instr[6:0]);
`else
  assign fmt_s = legalize_format(ImmSrc);
`endif

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr  (instr),
    .format (fmt_s),
    .imm    (imm_s)
  );

  // Target adder sits beside the extractor; carry out is dropped.
  always_comb begin
    new_entry_s.imm_op    = imm_s;
    new_entry_s.pc_target = pc + imm_s;
    new_entry_s.fmt       = fmt_s;
  end

  buf_state_e state_q, state_d;
  imm_entry_t out_q, out_d;
  imm_entry_t skid_q, skid_d;
  logic       out_valid_q, out_valid_d;
  logic       in_ready_q, in_ready_d;
  logic       accept_s, pop_s;

  assign accept_s = in_valid & in_ready_q;
  assign pop_s    = out_valid_q & out_ready;

  // Skid-buffer next state; handshake flags are precomputed from the next state.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = BUF_EMPTY;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept_s) begin
            state_d = BUF_ONE;
            out_d   = new_entry_s;
          end else begin
            state_d = BUF_EMPTY;
          end
        end
        BUF_ONE: begin
          if (accept_s && pop_s) begin
            out_d = new_entry_s;
          end else if (accept_s) begin
            state_d = BUF_FULL;
            skid_d  = new_entry_s;
          end else if (pop_s) begin
            state_d = BUF_EMPTY;
          end else begin
            state_d = BUF_ONE;
          end
        end
        BUF_FULL: begin
          if (pop_s) begin
            state_d = BUF_ONE;
            out_d   = skid_q;
          end else begin
            state_d = BUF_FULL;
          end
        end
        default: state_d = BUF_EMPTY;
      endcase
    end
    out_valid_d = (state_d != BUF_EMPTY);
    in_ready_d  = (state_d != BUF_FULL);
  end

  // State and data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      out_q       <= ENTRY_RST;
      skid_q      <= ENTRY_RST;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign ImmOp     = out_q.imm_op;
  assign PcTarget  = out_q.pc_target;
  assign Format    = out_q.fmt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a queue-based reference model plus a table of known vectors.
module tb_imm_gen_pipe;
  import types_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] pc;
  instr_format imm_src;

  logic        in_ready32, out_valid32, in_ready64, out_valid64;
  logic [31:0] imm32, tgt32;
  logic [63:0] imm64, tgt64;
  instr_format fmt32, fmt64;

  imm_gen_pipe #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .pc(pc[31:0]), .ImmSrc(imm_src), .out_valid(out_valid32),
    .out_ready(out_ready), .ImmOp(imm32), .PcTarget(tgt32), .Format(fmt32)
  );

  imm_gen_pipe #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .pc(pc), .ImmSrc(imm_src), .out_valid(out_valid64),
    .out_ready(out_ready), .ImmOp(imm64), .PcTarget(tgt64), .Format(fmt64)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] p;
    logic [2:0]  sel;
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
  } vec_t;

  exp_t model_q[$];
  vec_t vecs[6];

  function automatic logic [2:0] model_fmt(input logic [31:0] ins, input logic [2:0] sel);
    logic [2:0] f;
    f = (sel <= 3'd4) ? sel : 3'd0;
`ifdef IMM_AUTO_DECODE_EN
    case (ins[6:0])
      7'h23:        f = 3'd1;
      7'h37, 7'h17: f = 3'd2;
      7'h63:        f = 3'd3;
      7'h6F:        f = 3'd4;
      default:      f = 3'd0;
    endcase
`endif
    return f;
  endfunction

  // Immediate value as a signed number, assembled by weighting each field.
  function automatic logic [63:0] model_imm(input logic [31:0] ins, input logic [2:0] f);
    longint sx, v;
    sx = longint'($signed(ins));
    case (f)
      3'd1:    v = (sx >>> 25) * 32 + longint'((ins >> 7) & 32'h1F);
      3'd2:    v = (sx >>> 12) * 4096;
      3'd3:    v = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048
                   + longint'((ins >> 25) & 32'h3F) * 32 + longint'((ins >> 8) & 32'hF) * 2;
      3'd4:    v = (sx >>> 31) * 1048576 + longint'((ins >> 12) & 32'hFF) * 4096
                   + longint'(ins[20]) * 2048 + longint'((ins >> 21) & 32'h3FF) * 2;
      default: v = sx >>> 20;
    endcase
    return v;
  endfunction

  function automatic exp_t make_exp(input logic [31:0] ins, input logic [63:0] p,
                                    input logic [2:0] sel);
    exp_t e;
    e.fmt = model_fmt(ins, sel);
    e.imm = model_imm(ins, e.fmt);
    e.tgt = p + e.imm;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    exp_t e;
    chk({tag, ":out_valid32"}, 64'(out_valid32), 64'(model_q.size() > 0));
    chk({tag, ":out_valid64"}, 64'(out_valid64), 64'(model_q.size() > 0));
    chk({tag, ":in_ready32"},  64'(in_ready32),  64'(model_q.size() < 2));
    chk({tag, ":in_ready64"},  64'(in_ready64),  64'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      e = model_q[0];
      chk({tag, ":imm32"}, 64'(imm32), {32'h0, e.imm[31:0]});
      chk({tag, ":tgt32"}, 64'(tgt32), {32'h0, e.tgt[31:0]});
      chk({tag, ":fmt32"}, 64'(fmt32), 64'(e.fmt));
      chk({tag, ":imm64"}, imm64, e.imm);
      chk({tag, ":tgt64"}, tgt64, e.tgt);
      chk({tag, ":fmt64"}, 64'(fmt64), 64'(e.fmt));
    end
  endtask

  task automatic model_update();
    logic can_accept;
    if (flush) begin
      model_q.delete();
    end else begin
      can_accept = (model_q.size() < 2);
      if (model_q.size() > 0 && out_ready) void'(model_q.pop_front());
      if (in_valid && can_accept) model_q.push_back(make_exp(instr, pc, 3'(imm_src)));
    end
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check at the next fall.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] p,
                      input logic [2:0] sel, input logic ordy, input logic fl,
                      input string tag);
    in_valid  = v;
    instr     = ins;
    pc        = p;
    imm_src   = instr_format'(sel);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 32'h0, 64'h0, 3'd0, 1'b1, 1'b0, tag);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'h0; pc = 64'h0; imm_src = types_pkg::I;

    vecs[0] = '{32'hFFF00093, 64'h0,   3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0};
    vecs[1] = '{32'hFE000EE3, 64'h100, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0000_0000_0000_00FC, 3'd3};
    vecs[2] = '{32'h800000B7, 64'h1000, 3'd2, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_1000, 3'd2};
    vecs[3] = '{32'h0080006F, 64'h20,  3'd4, 64'h8, 64'h28, 3'd4};
    vecs[4] = '{32'hFE112E23, 64'h200, 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1FC, 3'd1};
    vecs[5] = '{32'h00500093, 64'h10,  3'd7, 64'h5, 64'h15, 3'd0};

    repeat (2) @(negedge clk);
    chk("rst:out_valid32", 64'(out_valid32), 64'h0);
    chk("rst:out_valid64", 64'(out_valid64), 64'h0);
    chk("rst:in_ready32",  64'(in_ready32),  64'h1);
    chk("rst:in_ready64",  64'(in_ready64),  64'h1);
    chk("rst:imm64",       imm64,            64'h0);
    chk("rst:tgt64",       tgt64,            64'h0);
    chk("rst:imm32",       64'(imm32),       64'h0);
    chk("rst:fmt64",       64'(fmt64),       64'h0);
    rst_n = 1'b1;
    idle("post_rst");

    for (int i = 0; i < 6; i++) begin
      step(1'b1, vecs[i].ins, vecs[i].p, vecs[i].sel, 1'b1, 1'b0, "vec");
      chk("vec:valid",  64'(out_valid64), 64'h1);
      chk("vec:imm64",  imm64,            vecs[i].imm);
      chk("vec:tgt64",  tgt64,            vecs[i].tgt);
      chk("vec:imm32",  64'(imm32),       {32'h0, vecs[i].imm[31:0]});
      chk("vec:tgt32",  64'(tgt32),       {32'h0, vecs[i].tgt[31:0]});
      chk("vec:fmt64",  64'(fmt64),       64'(vecs[i].fmt));
      idle("vec_drain");
    end

    // A, B back-to-back, downstream stalls; C waits until a slot frees.
    step(1'b1, 32'h00100093, 64'h1000, 3'd0, 1'b1, 1'b0, "seq_a");
    step(1'b1, 32'h00200093, 64'h2000, 3'd0, 1'b0, 1'b0, "seq_b");
    chk("seq:in_ready_full", 64'(in_ready64), 64'h0);
    step(1'b1, 32'h00300093, 64'h3000, 3'd0, 1'b0, 1'b0, "seq_c_wait");
    chk("seq:hold_a", imm64, 64'h1);
    step(1'b1, 32'h00300093, 64'h3000, 3'd0, 1'b0, 1'b0, "seq_c_wait2");
    step(1'b1, 32'h00300093, 64'h3000, 3'd0, 1'b1, 1'b0, "seq_pop_a");
    chk("seq:front_b", imm64, 64'h2);
    step(1'b1, 32'h00300093, 64'h3000, 3'd0, 1'b1, 1'b0, "seq_pop_b");
    chk("seq:front_c", imm64, 64'h3);
    idle("seq_pop_c");
    chk("seq:empty", 64'(out_valid64), 64'h0);

    // Flush while FULL with a transfer offered.
    step(1'b1, 32'h00A00093, 64'h40, 3'd0, 1'b0, 1'b0, "fl_a");
    step(1'b1, 32'h00B00093, 64'h44, 3'd0, 1'b0, 1'b0, "fl_b");
    step(1'b1, 32'h00C00093, 64'h48, 3'd0, 1'b0, 1'b1, "fl_full");
    chk("flush:out_valid", 64'(out_valid32), 64'h0);
    chk("flush:in_ready",  64'(in_ready32),  64'h1);
    idle("fl_idle1");
    idle("fl_idle2");
    // Flush in ONE while a new transfer would be accepted.
    step(1'b1, 32'h00D00093, 64'h50, 3'd0, 1'b0, 1'b0, "fl1_a");
    step(1'b1, 32'h00E00093, 64'h54, 3'd0, 1'b0, 1'b1, "fl1_one");
    idle("fl1_idle");

    // Asynchronous reset while FULL.
    step(1'b1, 32'h00F00093, 64'h60, 3'd0, 1'b0, 1'b0, "rs_a");
    step(1'b1, 32'h01000093, 64'h64, 3'd0, 1'b0, 1'b0, "rs_b");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst:out_valid32", 64'(out_valid32), 64'h0);
    chk("arst:in_ready32",  64'(in_ready32),  64'h1);
    chk("arst:out_valid64", 64'(out_valid64), 64'h0);
    chk("arst:in_ready64",  64'(in_ready64),  64'h1);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle("arst_idle");

`ifdef IMM_AUTO_DECODE_EN
    step(1'b1, 32'h00112223, 64'h80, 3'd4, 1'b1, 1'b0, "auto_s");
    chk("auto:fmt_s", 64'(fmt64), 64'h1);
    idle("auto_idle");
`endif

    for (int n = 0; n < 2000; n++) begin
      logic [31:0] ins;
      logic [2:0]  pick;
      ins  = $urandom;
      pick = 3'($urandom_range(0, 7));
      case (pick)
        3'd0: ins[6:0] = 7'b0100011;
        3'd1: ins[6:0] = 7'b1100011;
        3'd2: ins[6:0] = 7'b1101111;
        3'd3: ins[6:0] = 7'b0110111;
        default: ins = ins;
      endcase
      step($urandom_range(0, 3) != 0, ins, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
